// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Optional MEM_ARB_PERF_EN adds saturating grant/conflict counters.
module mem_port_arbiter #(
  parameter int unsigned RAM_AW     = 12,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_if_cnt,
  output logic [15:0]       perf_d_cnt,
  output logic [15:0]       perf_conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [1:0] WAIT_INIT = (RD_LATENCY >= 2) ? 2'(RD_LATENCY - 2) : 2'd0;

  state_t      state;
  logic        rr_last_d;
  logic        own_d;
  logic        op_we;
  logic        op_uns;
  logic        op_err;
  logic [1:0]  op_size;
  logic [1:0]  op_lane;
  logic [1:0]  wait_cnt;

  logic        idle;
  logic        grant_if;
  logic        grant_d;
  logic        misalign;
  logic        store_go;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        resp;
  logic        unused_bits;

  assign unused_bits = ^{if_addr[1:0], if_addr[31:RAM_AW+2], d_addr[31:RAM_AW+2]};

  // Grants are combinational in IDLE; rst gates them so outputs stay 0 during reset.
  assign idle     = (state == IDLE) && !rst;
  assign grant_if = idle && if_req && (!d_req || rr_last_d);
  assign grant_d  = idle && d_req && (!if_req || !rr_last_d);

  always_comb begin
    misalign   = 1'b0;
    lane_be    = 4'b1111;
    lane_wdata = d_wdata;
    case (d_size)
      2'b00: begin
        lane_be    = 4'b0001 << d_addr[1:0];
        lane_wdata = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        misalign   = d_addr[0];
        lane_be    = d_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{d_wdata[15:0]}};
      end
      default: misalign = (d_addr[1:0] != 2'b00);
    endcase
  end

  assign store_go  = grant_d && d_we && !misalign;
  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign mem_en    = grant_if || (grant_d && !misalign);
  assign mem_we    = store_go ? lane_be : '0;
  assign mem_wdata = store_go ? lane_wdata : '0;
  assign mem_addr  = grant_d  ? d_addr[RAM_AW+1:2] :
                     grant_if ? if_addr[RAM_AW+1:2] : '0;

  always_comb begin
    ld_byte = '0;
    case (op_lane)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_size)
      2'b00:   ld_ext = {{24{!op_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{!op_uns & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign resp      = (state == RESP);
  assign if_rvalid = resp && !own_d;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rvalid  = resp && own_d;
  assign d_err     = d_rvalid && op_err;
  assign d_rdata   = (d_rvalid && !op_err && !op_we) ? ld_ext : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last_d <= 1'b1;
      own_d     <= 1'b0;
      op_we     <= 1'b0;
      op_uns    <= 1'b0;
      op_err    <= 1'b0;
      op_size   <= '0;
      op_lane   <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_d) begin
            rr_last_d <= grant_d;
            own_d     <= grant_d;
            op_we     <= d_we;
            op_uns    <= d_unsigned;
            op_size   <= d_size;
            op_lane   <= d_addr[1:0];
            op_err    <= grant_d && misalign;
            // Misaligned accesses never touch the RAM, so they skip the wait.
            if ((grant_d && misalign) || (RD_LATENCY <= 1)) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_cnt       <= '0;
      perf_d_cnt        <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (grant_if && (perf_if_cnt != '1)) perf_if_cnt <= perf_if_cnt + 16'd1;
      if (grant_d && (perf_d_cnt != '1))   perf_d_cnt  <= perf_d_cnt + 16'd1;
      if (idle && if_req && d_req && (perf_conflict_cnt != '1))
        perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
